geom_buf_alloc: RTL

Geometry buffer allocator sitting directly downstream of the SPI packet deserializer. Accepts de-serialized vertex and triangle buffer streams (start + count, then one word per element), assigns each buffer a contiguous region in vertex or triangle RAM plus a buffer ID, and writes each element to RAM. Once the last element arrives, it commits a descriptor (base, count) to the descriptor tables and reports the ID for return to the MCU. All inputs are synchronous to `clk`; clock-domain crossing is done upstream.

---
 rtl/geom_buf_alloc.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/geom_buf_alloc.sv
// Geometry buffer allocator: carves vertex/triangle RAM into
// contiguous buffers, streams elements in, commits descriptors.
module geom_buf_alloc #(
  parameter int VTX_W    = 108,
  parameter int TRI_W    = 24,
  parameter int MAX_VERT = 5000,
  parameter int MAX_TRI  = 5000,
  parameter int MAX_BUF  = 256,
  parameter int VA_W     = $clog2(MAX_VERT),
  parameter int TA_W     = $clog2(MAX_TRI)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wipe,
  input  logic             vert_start,
  input  logic [7:0]       vert_cnt_m1,
  input  logic             vert_valid,
  input  logic [VTX_W-1:0] vert_data,
  input  logic             tri_start,
  input  logic [7:0]       tri_cnt_m1,
  input  logic             tri_valid,
  input  logic [TRI_W-1:0] tri_data,
  output logic             vram_we,
  output logic [VA_W-1:0]  vram_addr,
  output logic [VTX_W-1:0] vram_wdata,
  output logic             tram_we,
  output logic [TA_W-1:0]  tram_addr,
  output logic [TRI_W-1:0] tram_wdata,
  output logic             desc_we,
  output logic             desc_kind,
  output logic [7:0]       desc_id,
  output logic [12:0]      desc_base,
  output logic [7:0]       desc_cnt_m1,
  output logic             done_valid,
  output logic             done_kind,
  output logic [7:0]       done_id,
  output logic             err_valid,
  output logic [1:0]       err_code,
  output logic             busy
);

  localparam int AW = 13;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_COMMIT
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0] vtop_q, vtop_d, ttop_q, ttop_d;
  logic [8:0]    vid_q, vid_d, tid_q, tid_d;
  logic [AW-1:0] base_q, base_d;
  logic [8:0]    idx_q, idx_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          kind_q, kind_d;

  logic             vram_we_q, vram_we_d;
  logic [VA_W-1:0]  vram_addr_q, vram_addr_d;
  logic [VTX_W-1:0] vram_wdata_q, vram_wdata_d;
  logic             tram_we_q, tram_we_d;
  logic [TA_W-1:0]  tram_addr_q, tram_addr_d;
  logic [TRI_W-1:0] tram_wdata_q, tram_wdata_d;
  logic             desc_we_q, desc_we_d;
  logic             desc_kind_q, desc_kind_d;
  logic [7:0]       desc_id_q, desc_id_d;
  logic [12:0]      desc_base_q, desc_base_d;
  logic [7:0]       desc_cnt_q, desc_cnt_d;
  logic             done_valid_q, done_valid_d;
  logic             err_valid_q, err_valid_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             busy_q, busy_d;

  logic [13:0] v_end, t_end;
  logic        v_fit, t_fit, v_idok, t_idok;
  logic        match_v, wrong_v, last;
  logic [AW-1:0] wr_off;

  // 14-bit sums so a region ending exactly at the RAM depth still fits
  assign v_end  = {1'b0, vtop_q} + {6'd0, vert_cnt_m1} + 14'd1;
  assign t_end  = {1'b0, ttop_q} + {6'd0, tri_cnt_m1} + 14'd1;
  assign v_fit  = v_end <= 14'(MAX_VERT);
  assign t_fit  = t_end <= 14'(MAX_TRI);
  assign v_idok = vid_q < 9'(MAX_BUF);
  assign t_idok = tid_q < 9'(MAX_BUF);
  assign match_v = kind_q ? tri_valid : vert_valid;
  assign wrong_v = kind_q ? vert_valid : tri_valid;
  assign last    = idx_q == {1'b0, cnt_q};
  assign wr_off  = base_q + AW'(idx_q);

  always_comb begin
    state_d      = state_q;
    vtop_d       = vtop_q;
    ttop_d       = ttop_q;
    vid_d        = vid_q;
    tid_d        = tid_q;
    base_d       = base_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    kind_d       = kind_q;
    vram_we_d    = 1'b0;
    vram_addr_d  = vram_addr_q;
    vram_wdata_d = vram_wdata_q;
    tram_we_d    = 1'b0;
    tram_addr_d  = tram_addr_q;
    tram_wdata_d = tram_wdata_q;
    desc_we_d    = 1'b0;
    desc_kind_d  = desc_kind_q;
    desc_id_d    = desc_id_q;
    desc_base_d  = desc_base_q;
    desc_cnt_d   = desc_cnt_q;
    done_valid_d = 1'b0;
    err_valid_d  = 1'b0;
    err_code_d   = 2'd0;
    if (wipe) begin
      state_d = S_IDLE;
      vtop_d  = '0;
      ttop_d  = '0;
      vid_d   = '0;
      tid_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (vert_start) begin
            if (!v_fit) begin
              err_valid_d = 1'b1;
              err_code_d  = 2'd1;
            end else if (!v_idok) begin
              err_valid_d = 1'b1;
              err_code_d  = 2'd2;
            end else begin
              state_d = S_FILL;
              base_d  = vtop_q;
              cnt_d   = vert_cnt_m1;
              kind_d  = 1'b0;
              idx_d   = '0;
            end
            if (tri_start && !err_valid_d) begin
              err_valid_d = 1'b1;
              err_code_d  = 2'd3;
            end
          end else if (tri_start) begin
            if (!t_fit) begin
              err_valid_d = 1'b1;
              err_code_d  = 2'd1;
            end else if (!t_idok) begin
              err_valid_d = 1'b1;
              err_code_d  = 2'd2;
            end else begin
              state_d = S_FILL;
              base_d  = ttop_q;
              cnt_d   = tri_cnt_m1;
              kind_d  = 1'b1;
              idx_d   = '0;
            end
          end else if (vert_valid || tri_valid) begin
            err_valid_d = 1'b1;
            err_code_d  = 2'd3;
          end
        end
        S_FILL: begin
          if (vert_start || tri_start) begin
            // abort: region and ID are reused by the next buffer
            err_valid_d = 1'b1;
            err_code_d  = 2'd3;
            state_d     = S_IDLE;
          end else begin
            if (match_v) begin
              idx_d = idx_q + 9'd1;
              if (last) state_d = S_COMMIT;
              if (kind_q) begin
                tram_we_d    = 1'b1;
                tram_addr_d  = TA_W'(wr_off);
                tram_wdata_d = tri_data;
              end else begin
                vram_we_d    = 1'b1;
                vram_addr_d  = VA_W'(wr_off);
                vram_wdata_d = vert_data;
              end
            end
            if (wrong_v) begin
              err_valid_d = 1'b1;
              err_code_d  = 2'd3;
            end
          end
        end
        S_COMMIT: begin
          desc_we_d    = 1'b1;
          done_valid_d = 1'b1;
          desc_kind_d  = kind_q;
          desc_id_d    = kind_q ? tid_q[7:0] : vid_q[7:0];
          desc_base_d  = base_q;
          desc_cnt_d   = cnt_q;
          if (kind_q) begin
            ttop_d = ttop_q + AW'(cnt_q) + AW'(1);
            tid_d  = tid_q + 9'd1;
          end else begin
            vtop_d = vtop_q + AW'(cnt_q) + AW'(1);
            vid_d  = vid_q + 9'd1;
          end
          if (vert_start || tri_start || vert_valid || tri_valid) begin
            err_valid_d = 1'b1;
            err_code_d  = 2'd3;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = state_d != S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      vtop_q       <= '0;
      ttop_q       <= '0;
      vid_q        <= '0;
      tid_q        <= '0;
      base_q       <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      kind_q       <= 1'b0;
      vram_we_q    <= 1'b0;
      vram_addr_q  <= '0;
      vram_wdata_q <= '0;
      tram_we_q    <= 1'b0;
      tram_addr_q  <= '0;
      tram_wdata_q <= '0;
      desc_we_q    <= 1'b0;
      desc_kind_q  <= 1'b0;
      desc_id_q    <= '0;
      desc_base_q  <= '0;
      desc_cnt_q   <= '0;
      done_valid_q <= 1'b0;
      err_valid_q  <= 1'b0;
      err_code_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vtop_q       <= vtop_d;
      ttop_q       <= ttop_d;
      vid_q        <= vid_d;
      tid_q        <= tid_d;
      base_q       <= base_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      kind_q       <= kind_d;
      vram_we_q    <= vram_we_d;
      vram_addr_q  <= vram_addr_d;
      vram_wdata_q <= vram_wdata_d;
      tram_we_q    <= tram_we_d;
      tram_addr_q  <= tram_addr_d;
      tram_wdata_q <= tram_wdata_d;
      desc_we_q    <= desc_we_d;
      desc_kind_q  <= desc_kind_d;
      desc_id_q    <= desc_id_d;
      desc_base_q  <= desc_base_d;
      desc_cnt_q   <= desc_cnt_d;
      done_valid_q <= done_valid_d;
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
      busy_q       <= busy_d;
    end
  end

  assign vram_we     = vram_we_q;
  assign vram_addr   = vram_addr_q;
  assign vram_wdata  = vram_wdata_q;
  assign tram_we     = tram_we_q;
  assign tram_addr   = tram_addr_q;
  assign tram_wdata  = tram_wdata_q;
  assign desc_we     = desc_we_q;
  assign desc_kind   = desc_kind_q;
  assign desc_id     = desc_id_q;
  assign desc_base   = desc_base_q;
  assign desc_cnt_m1 = desc_cnt_q;
  assign done_valid  = done_valid_q;
  assign done_kind   = desc_kind_q;
  assign done_id     = desc_id_q;
  assign err_valid   = err_valid_q;
  assign err_code    = err_code_q;
  assign busy        = busy_q;

endmodule
